// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: shares one generic memory between the fetch port and
// the MEM-stage port. Each transaction runs IDLE -> ACCESS -> RESPOND, which
// gives a fixed 2-cycle request-to-ack latency.
// Optional build macro: ARB_ROUND_ROBIN_EN. When it is defined, ties are
// broken by a last-winner bit instead of fixed data-port priority.
module memory_port_arbiter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             fetchReq,
    input  logic [DEPTH-1:0] fetchAddress,
    output logic             fetchAck,
    output logic [WIDTH-1:0] fetchData,
    input  logic             dataReq,
    input  logic             dataWrite,
    input  logic [DEPTH-1:0] dataAddress,
    input  logic [WIDTH-1:0] dataWriteData,
    output logic             dataAck,
    output logic [WIDTH-1:0] dataReadData,
    output logic [DEPTH-1:0] memAddressRead,
    output logic [DEPTH-1:0] memAddressWrite,
    output logic             memEnableRead,
    output logic             memEnableWrite,
    output logic [WIDTH-1:0] memDataIn,
    input  logic [WIDTH-1:0] memDataOut
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               sel_data_q, sel_data_d;     // 1: data port owns the transaction
    logic               wr_q, wr_d;
    logic [DEPTH-1:0]   addr_q, addr_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;
    logic               fetch_ack_q, fetch_ack_d;
    logic               data_ack_q, data_ack_d;
    logic [WIDTH-1:0]   fetch_data_q, fetch_data_d;
    logic [WIDTH-1:0]   data_rd_q, data_rd_d;
    logic               grant_data_s;
`ifdef ARB_ROUND_ROBIN_EN
    logic               last_data_q, last_data_d;   // 1: data port won the previous grant
`endif

    // Choose the winner among the current requesters.
    always_comb begin
        grant_data_s = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        if (dataReq && fetchReq) begin
            grant_data_s = ~last_data_q;
        end else begin
            grant_data_s = dataReq;
        end
`else
        grant_data_s = dataReq;
`endif
    end

    // Next-state, command latch, ack and read-data capture.
    always_comb begin
        state_d      = state_q;
        sel_data_d   = sel_data_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        fetch_ack_d  = 1'b0;
        data_ack_d   = 1'b0;
        fetch_data_d = fetch_data_q;
        data_rd_d    = data_rd_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_data_d  = last_data_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (fetchReq || dataReq) begin
                    state_d    = ST_ACCESS;
                    sel_data_d = grant_data_s;
                    if (grant_data_s) begin
                        addr_d  = dataAddress;
                        wr_d    = dataWrite;
                        wdata_d = dataWriteData;
                    end else begin
                        addr_d  = fetchAddress;
                        wr_d    = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESPOND;
`ifdef ARB_ROUND_ROBIN_EN
                last_data_d = sel_data_q;
`endif
                if (sel_data_q) begin
                    data_ack_d = 1'b1;
                    if (!wr_q) begin
                        data_rd_d = memDataOut;
                    end else begin
                        data_rd_d = data_rd_q;
                    end
                end else begin
                    fetch_ack_d  = 1'b1;
                    fetch_data_d = memDataOut;
                end
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            sel_data_q   <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            fetch_ack_q  <= 1'b0;
            data_ack_q   <= 1'b0;
            fetch_data_q <= '0;
            data_rd_q    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_data_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sel_data_q   <= sel_data_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            fetch_ack_q  <= fetch_ack_d;
            data_ack_q   <= data_ack_d;
            fetch_data_q <= fetch_data_d;
            data_rd_q    <= data_rd_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_data_q  <= last_data_d;
`endif
        end
    end

    // Memory enables live only in ACCESS and are killed at once by reset so
    // a reset landing mid-access never commits a write.
    assign memEnableRead   = (state_q == ST_ACCESS) && !wr_q && !reset;
    assign memEnableWrite  = (state_q == ST_ACCESS) &&  wr_q && !reset;
    assign memAddressRead  = addr_q;
    assign memAddressWrite = addr_q;
    assign memDataIn       = wdata_q;

    assign fetchAck     = fetch_ack_q;
    assign fetchData    = fetch_data_q;
    assign dataAck      = data_ack_q;
    assign dataReadData = data_rd_q;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Scoreboard bench for memory_port_arbiter: the driver issues request rounds
// and pushes expected transactions in grant order computed from a
// transaction-level model; a negedge monitor checks accesses and acks.
module tb_memory_port_arbiter;

    logic        clock;
    logic        reset;
    logic        fetchReq;
    logic [31:0] fetchAddress;
    logic        fetchAck;
    logic [31:0] fetchData;
    logic        dataReq;
    logic        dataWrite;
    logic [31:0] dataAddress;
    logic [31:0] dataWriteData;
    logic        dataAck;
    logic [31:0] dataReadData;
    logic [31:0] memAddressRead;
    logic [31:0] memAddressWrite;
    logic        memEnableRead;
    logic        memEnableWrite;
    logic [31:0] memDataIn;
    logic [31:0] memDataOut;

    memory_port_arbiter #(.WIDTH(32), .DEPTH(32)) dut (
        .clock(clock), .reset(reset),
        .fetchReq(fetchReq), .fetchAddress(fetchAddress),
        .fetchAck(fetchAck), .fetchData(fetchData),
        .dataReq(dataReq), .dataWrite(dataWrite), .dataAddress(dataAddress),
        .dataWriteData(dataWriteData), .dataAck(dataAck), .dataReadData(dataReadData),
        .memAddressRead(memAddressRead), .memAddressWrite(memAddressWrite),
        .memEnableRead(memEnableRead), .memEnableWrite(memEnableWrite),
        .memDataIn(memDataIn), .memDataOut(memDataOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Shared memory instance (256 words, combinational read).
    bit   [31:0] mem_arr [256];
    logic        pl_we = 1'b0;
    logic [7:0]  pl_addr = 8'd0;
    logic [31:0] pl_data = 32'd0;
    always @(posedge clock) begin
        if (pl_we) mem_arr[pl_addr] <= pl_data;
        else if (memEnableWrite) mem_arr[memAddressWrite[7:0]] <= memDataIn;
    end
    assign memDataOut = mem_arr[memAddressRead[7:0]];

    typedef struct {
        bit          is_data;
        bit          is_write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          exp_cycle;
        logic [31:0] exp_fd;
        logic [31:0] exp_dd;
    } exp_t;
    exp_t sb[$];

    // Reference model state
    bit   [31:0] ref_mem [256];
    logic [31:0] m_fd = 32'd0;
    logic [31:0] m_dd = 32'd0;
    bit          last_data = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: checks memory accesses and acks against the scoreboard.
    always @(negedge clock) begin
        if (reset) begin
            chk("enable_in_reset", {62'd0, memEnableRead, memEnableWrite}, 64'd0);
        end
        if (memEnableRead || memEnableWrite) begin
            chk("enable_overlap", {63'd0, memEnableRead && memEnableWrite}, 64'd0);
            if (sb.size() == 0) begin
                chk("unexpected_access", 64'd1, 64'd0);
            end else begin
                chk("access_is_write", {63'd0, memEnableWrite}, {63'd0, sb[0].is_write});
                chk("access_cycle", 64'(cyc), 64'(sb[0].exp_cycle - 1));
                chk("access_raddr", {32'd0, memAddressRead}, {32'd0, sb[0].addr});
                if (sb[0].is_write) begin
                    chk("access_waddr", {32'd0, memAddressWrite}, {32'd0, sb[0].addr});
                    chk("access_wdata", {32'd0, memDataIn}, {32'd0, sb[0].wdata});
                end
            end
        end
        if (fetchAck || dataAck) begin
            exp_t e;
            chk("ack_overlap", {63'd0, fetchAck && dataAck}, 64'd0);
            if (sb.size() == 0) begin
                chk("unexpected_ack", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("ack_port", {63'd0, dataAck}, {63'd0, e.is_data});
                chk("ack_cycle", 64'(cyc), 64'(e.exp_cycle));
                chk("fetchData", {32'd0, fetchData}, {32'd0, e.exp_fd});
                chk("dataReadData", {32'd0, dataReadData}, {32'd0, e.exp_dd});
            end
        end
    end

    // One round of requests issued from IDLE; expected results in grant order.
    task automatic do_round(input bit f, input bit d, input bit dw,
                            input logic [7:0] fa, input logic [7:0] da, input logic [31:0] wd);
        int  k;
        int  budget;
        bit  first_data;
        bit  port;
        int  n;
        exp_t e;
        @(negedge clock); #1;
        k = cyc;
        fetchReq = f; fetchAddress = {24'd0, fa};
        dataReq = d; dataWrite = dw; dataAddress = {24'd0, da}; dataWriteData = wd;
        if (f && d) begin
`ifdef ARB_ROUND_ROBIN_EN
            first_data = !last_data;
`else
            first_data = 1'b1;
`endif
        end else begin
            first_data = d;
        end
        n = (f && d) ? 2 : ((f || d) ? 1 : 0);
        for (int i = 0; i < n; i++) begin
            port = (i == 0) ? first_data : !first_data;
            e.is_data = port;
            if (port) begin
                e.is_write = dw; e.addr = {24'd0, da}; e.wdata = wd;
                if (dw) ref_mem[da] = wd;
                else m_dd = ref_mem[da];
            end else begin
                e.is_write = 1'b0; e.addr = {24'd0, fa}; e.wdata = 32'd0;
                m_fd = ref_mem[fa];
            end
            e.exp_cycle = k + 2 + 3 * i;
            e.exp_fd = m_fd;
            e.exp_dd = m_dd;
            last_data = port;
            sb.push_back(e);
        end
        budget = 0;
        while ((fetchReq || dataReq) && budget < 20) begin
            @(negedge clock); #1;
            budget++;
            if (fetchAck) fetchReq = 1'b0;
            if (dataAck) dataReq = 1'b0;
        end
        if (fetchReq || dataReq) begin
            chk("handshake_timeout", 64'd1, 64'd0);
            fetchReq = 1'b0; dataReq = 1'b0;
            sb.delete();
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_fetchAck"}, {63'd0, fetchAck}, 64'd0);
        chk({tag, "_dataAck"}, {63'd0, dataAck}, 64'd0);
        chk({tag, "_fetchData"}, {32'd0, fetchData}, 64'd0);
        chk({tag, "_dataReadData"}, {32'd0, dataReadData}, 64'd0);
        chk({tag, "_memAddressRead"}, {32'd0, memAddressRead}, 64'd0);
        chk({tag, "_memAddressWrite"}, {32'd0, memAddressWrite}, 64'd0);
        chk({tag, "_memDataIn"}, {32'd0, memDataIn}, 64'd0);
        chk({tag, "_memEnables"}, {62'd0, memEnableRead, memEnableWrite}, 64'd0);
    endtask

    initial begin
        int k;
        reset = 1'b1;
        fetchReq = 1'b0; fetchAddress = 32'd0;
        dataReq = 1'b0; dataWrite = 1'b0; dataAddress = 32'd0; dataWriteData = 32'd0;

        // Reset held while preloading mem[0x10]
        @(negedge clock); #1;
        pl_we = 1'b1; pl_addr = 8'h10; pl_data = 32'hDEADBEEF;
        ref_mem[8'h10] = 32'hDEADBEEF;
        @(negedge clock); #1;
        pl_we = 1'b0;
        @(negedge clock); #1;
        check_outputs_zero("reset");
        reset = 1'b0;

        // Directed: fetch read, data write + readback, fetch of written word, tie
        do_round(1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 32'd0);
        do_round(1'b0, 1'b1, 1'b1, 8'h00, 8'h20, 32'h12345678);
        do_round(1'b0, 1'b1, 1'b0, 8'h00, 8'h20, 32'd0);
        do_round(1'b1, 1'b1, 1'b0, 8'h10, 8'h20, 32'd0);
        do_round(1'b1, 1'b1, 1'b0, 8'h20, 8'h10, 32'd0);
        do_round(1'b1, 1'b1, 1'b1, 8'h40, 8'h40, 32'hCAFEF00D);

        // Reset landing in the ACCESS cycle of a write to 0x30
        @(negedge clock); #1;
        k = cyc;
        dataReq = 1'b1; dataWrite = 1'b1; dataAddress = 32'h30; dataWriteData = 32'hA5A5A5A5;
        begin
            exp_t e;
            e.is_data = 1'b1; e.is_write = 1'b1; e.addr = 32'h30; e.wdata = 32'hA5A5A5A5;
            e.exp_cycle = k + 2; e.exp_fd = m_fd; e.exp_dd = m_dd;
            sb.push_back(e);
        end
        @(negedge clock); #1;
        reset = 1'b1; dataReq = 1'b0; dataWrite = 1'b0;
        sb.delete();
        @(negedge clock); #1;
        chk("midreset_no_ack", {63'd0, dataAck}, 64'd0);
        reset = 1'b0;
        @(negedge clock); #1;
        chk("midreset_mem30", {32'd0, mem_arr[8'h30]}, 64'd0);
        check_outputs_zero("midreset");
        m_fd = 32'd0; m_dd = 32'd0; last_data = 1'b0;
        do_round(1'b0, 1'b1, 1'b0, 8'h00, 8'h30, 32'd0);
        do_round(1'b1, 1'b1, 1'b0, 8'h30, 8'h10, 32'd0);

        // Randomized rounds
        for (int r = 0; r < 80; r++) begin
            int kind;
            kind = $urandom_range(1, 3);
            do_round(kind[0], kind[1], 1'($urandom_range(0, 1)),
                     8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        repeat (4) @(negedge clock);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
